// File: rtl/gzip_output_packer_pkg.sv
// Shared types and constants for the gzip output packer.
package gzip_output_packer_pkg;
  localparam int AXI_DATA_BITS = 512;
  localparam int AXI_BYTES     = AXI_DATA_BITS / 8;

  // Holds 0..AXI_BYTES inclusive, i.e. a popcount of a full tkeep.
  typedef logic [$clog2(AXI_BYTES):0] byte_cnt_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} pk_state_e;
endpackage

// File: rtl/gzip_output_packer_if.sv
// AXI4-Stream data bus used on both sides of the packer.
interface gzip_output_packer_if #(
  parameter int DATA_BITS = gzip_output_packer_pkg::AXI_DATA_BITS
);
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport m (output tdata, tkeep, tvalid, tlast, input tready);
  modport s (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/gzip_output_packer_keep_compactor.sv
// Combinational byte compactor: kept bytes move to the low end in ascending
// index order, unused upper bytes are zero, n is the popcount of tkeep.
module keep_compactor
  import gzip_output_packer_pkg::*;
#(
  parameter  int DATA_BITS = AXI_DATA_BITS,
  localparam int W         = DATA_BITS / 8,
  localparam int CW        = $clog2(W) + 1
) (
  input  logic [DATA_BITS-1:0] tdata,
  input  logic [W-1:0]         tkeep,
  output logic [DATA_BITS-1:0] dense,
  output logic [CW-1:0]        n
);
  always_comb begin
    logic [CW-1:0] pos;
    dense = '0;
    pos   = '0;
    // pos is the running prefix sum of tkeep: destination slot of byte i
    for (int i = 0; i < W; i++) begin
      if (tkeep[i]) begin
        dense[{pos[CW-2:0], 3'b000} +: 8] = tdata[i*8 +: 8];
        pos = pos + CW'(1);
      end
    end
    n = pos;
  end
endmodule

// File: rtl/gzip_output_packer.sv
// Packs sparse-tkeep AXI4S beats into dense full beats, preserving tlast.
// Optional per-frame byte counter: GZIP_OUTPUT_PACKER_BYTE_COUNT_EN.
module gzip_output_packer
  import gzip_output_packer_pkg::*;
#(
  parameter  int DATA_BITS = AXI_DATA_BITS,
  parameter  int CNT_BITS  = 32,
  localparam int W         = DATA_BITS / 8,
  localparam int FW        = $clog2(W),
  localparam int CW        = FW + 1,
  localparam int SW        = FW + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gzip_output_packer_if.s      i_data,
  gzip_output_packer_if.m      o_data,
  output logic [CNT_BITS-1:0]  o_frame_bytes,
  output logic                 o_frame_done
);
  localparam logic [SW-1:0] W_S = SW'(W);

  pk_state_e              state, state_d;
  logic [DATA_BITS-1:0]   res, res_d;
  logic [FW-1:0]          fill, fill_d;
  logic                   out_valid, out_valid_d;
  logic [DATA_BITS-1:0]   out_data, out_data_d;
  logic [W-1:0]           out_keep, out_keep_d;
  logic                   out_last, out_last_d;

  logic [DATA_BITS-1:0]   dense;
  logic [CW-1:0]          n;
  logic [SW-1:0]          sum;
  logic [2*DATA_BITS-1:0] wide;
  logic                   can_load, in_ready, accept;

  function automatic logic [W-1:0] keep_mask(input logic [SW-1:0] c);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = (SW'(i) < c);
    return m;
  endfunction

  keep_compactor #(.DATA_BITS(DATA_BITS)) u_cmp (
    .tdata (i_data.tdata),
    .tkeep (i_data.tkeep),
    .dense (dense),
    .n     (n)
  );

  always_comb begin
    can_load    = !out_valid || o_data.tready;
    in_ready    = (state == RUN) && can_load;
    accept      = in_ready && i_data.tvalid;
    sum         = {2'b00, fill} + {1'b0, n};
    // residue bytes at/above fill are always zero, so OR-merge is exact
    wide        = {{DATA_BITS{1'b0}}, res} | ({{DATA_BITS{1'b0}}, dense} << {fill, 3'b000});
    state_d     = state;
    res_d       = res;
    fill_d      = fill;
    out_valid_d = out_valid && !o_data.tready;
    out_data_d  = out_data;
    out_keep_d  = out_keep;
    out_last_d  = out_last;
    case (state)
      RUN: if (accept) begin
        if (sum >= W_S) begin
          out_valid_d = 1'b1;
          out_data_d  = wide[DATA_BITS-1:0];
          out_keep_d  = '1;
          out_last_d  = i_data.tlast && (sum == W_S);
          res_d       = wide[2*DATA_BITS-1:DATA_BITS];
          fill_d      = FW'(sum - W_S);
          if (i_data.tlast && (sum != W_S)) state_d = FLUSH;
        end else if (i_data.tlast) begin
          // also covers sum==0: a keep-less tlast beat marks the boundary
          out_valid_d = 1'b1;
          out_data_d  = wide[DATA_BITS-1:0];
          out_keep_d  = keep_mask(sum);
          out_last_d  = 1'b1;
          res_d       = '0;
          fill_d      = '0;
        end else begin
          res_d  = wide[DATA_BITS-1:0];
          fill_d = sum[FW-1:0];
        end
      end
      FLUSH: if (can_load) begin
        out_valid_d = 1'b1;
        out_data_d  = res;
        out_keep_d  = keep_mask({2'b00, fill});
        out_last_d  = 1'b1;
        res_d       = '0;
        fill_d      = '0;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      res       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      res       <= res_d;
      fill      <= fill_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_keep  <= out_keep_d;
      out_last  <= out_last_d;
    end
  end

  assign i_data.tready = in_ready;
  assign o_data.tvalid = out_valid;
  assign o_data.tdata  = out_data;
  assign o_data.tkeep  = out_keep;
  assign o_data.tlast  = out_last;

`ifdef GZIP_OUTPUT_PACKER_BYTE_COUNT_EN
  logic [CNT_BITS-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt     <= '0;
      o_frame_bytes <= '0;
      o_frame_done  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (accept) begin
        if (i_data.tlast) begin
          o_frame_bytes <= frame_cnt + CNT_BITS'(n);
          o_frame_done  <= 1'b1;
          frame_cnt     <= '0;
        end else begin
          frame_cnt <= frame_cnt + CNT_BITS'(n);
        end
      end
    end
  end
`else
  assign o_frame_bytes = '0;
  assign o_frame_done  = 1'b0;
`endif
endmodule

// File: doc/gzip_output_packer.md
Name: gzip_output_packer

Overview:
- Sits directly downstream of the gzip wrapper's output FIFO and upstream of the host write path.
- Takes 512-bit compressed beats whose tkeep may be sparse or non-normalized and packs the valid bytes densely, in order, into full 512-bit beats.
- Only the final beat of a frame may be partial, and its tkeep is then a contiguous low-order prefix.
- Preserves frame boundaries (tlast).

Parameters:
- DATA_BITS, 512, width of the input and output tdata; byte count W = DATA_BITS/8.
- CNT_BITS, 32, width of the per-frame byte counter (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_data  AXI4S.s  DATA_BITS  compressed input; tkeep arbitrary, tlast marks frame end.
- o_data  AXI4S.m  DATA_BITS  packed output.
- o_frame_bytes  out  CNT_BITS  byte count of the last completed frame (optional feature).
- o_frame_done  out  1  one-cycle pulse when o_frame_bytes updates (optional feature).

Behaviour:
- Reset values: o_data.tvalid=0, tkeep=0, tlast=0, tdata=0; residue fill=0; state=RUN; o_frame_bytes=0; o_frame_done=0.
- Residue buffer: W bytes plus fill counter 0..W-1 (clog2(W) bits), low-order packed.
- i_data.tready = (state==RUN) && (!o_data.tvalid || o_data.tready). The output register is a single stage and may be refilled on the same cycle it drains.
- Byte compaction on an accepted beat:
  - n = popcount(tkeep).
  - Valid bytes are ordered by ascending byte index.
  - They are appended at residue offset fill; the offset is computed by prefix-sum of tkeep.
- sum = fill + n, computed with clog2(W)+2 bits.
- If sum >= W:
  - Emit the low W bytes, tkeep all ones, on the next cycle.
  - New fill = sum - W; the remaining bytes shift down.
  - tlast = i.tlast && (sum == W).
- If sum < W and !i.tlast: no output; fill = sum.
- tlast cases:
  - sum < W and sum > 0: emit the residue with tkeep = (1<<sum)-1, tlast=1, then fill=0.
  - sum == 0 and the frame is empty (no bytes since the last tlast): emit one beat with tkeep=0 and tlast=1, so the boundary is preserved.
  - sum > W: emit the full beat (tlast=0) and enter FLUSH. In FLUSH, tready=0; once the output slot is free, emit the remainder with a prefix tkeep and tlast=1, set fill=0, and return to RUN.
- Empty beats (tkeep=0, tlast=0) are accepted and cause no change.
- Latency: one cycle from input acceptance to output tvalid. In FLUSH, one extra beat.
- Throughput: one beat per cycle except for the single FLUSH bubble after a frame that ends with sum > W.
- Output stability: tdata, tkeep and tlast are held stable while tvalid=1 and tready=0.
- Reset mid-frame: the residue and any partial frame are discarded; the next beat starts a new frame.

Optional Feature:
- Macro GZIP_OUTPUT_PACKER_BYTE_COUNT_EN.
- When defined:
  - A CNT_BITS counter accumulates n per accepted beat.
  - On tlast acceptance, o_frame_bytes takes the frame total (including that beat) and o_frame_done pulses for 1 cycle.
  - The counter clears for the next frame and wraps modulo 2^CNT_BITS.
- When undefined: o_frame_bytes=0 and o_frame_done=0 constantly, and no counter logic is built.

Decomposition:
- Shared package `common`:
  - byte-count typedef sized clog2(W)+1.
  - packer state enum {RUN, FLUSH}.
  - the existing AXI_DATA_BITS constant, used as the DATA_BITS default.
- Sub-module keep_compactor: combinational.
  - Inputs: tdata and tkeep.
  - Outputs: dense low-order bytes and n (popcount).
  - Verified standalone.

Test Plan:
- Two beats with full tkeep, second with tlast -> two outputs, tkeep=all-ones, tlast on the second only, no bubble.
- Three beats, each with tkeep=0x00000000_0000FFFF (16 bytes), tlast on the third -> one output, tkeep=0x0000FFFF_FFFFFFFF (48 bytes), bytes in order, tlast=1.
- Beat with 40 valid bytes, then beat with 40 valid bytes and tlast -> full beat (64 bytes, tlast=0), FLUSH bubble with tready=0, then 16-byte beat tkeep=0xFFFF and tlast=1; o_frame_bytes=80 under the macro.
- Single beat with tkeep=0 and tlast=1 -> one output beat, tkeep=0, tlast=1; o_frame_bytes=0.
- Non-contiguous tkeep 0xAAAA...AA (32 odd bytes) ×2 with tlast -> one full beat containing the odd-index bytes in order, tlast=1.
- o_data.tready held low for 5 cycles mid-stream, plus rst asserted mid-frame -> output stable while stalled, no data lost or duplicated; after reset, tvalid=0, fill=0, and the next frame packs from offset 0.
